// File: rtl/io_handshake_ctrl.sv
// Valid/ready sequencer for the INPUT/OUTPUT instructions, stalling the control unit until the port responds.
// Optional watchdog timeout is enabled by defining IO_TIMEOUT_EN.
module io_handshake_ctrl #(
    parameter int DW         = 8,
    parameter int TMO_CYCLES = 255,
    parameter int TW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          io_req,
    input  logic          io_op,
    input  logic [DW-1:0] wr_data,
    output logic          stall,
    output logic          done,
    output logic [DW-1:0] rd_data,
    output logic          rd_wr,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          timeout
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_WAIT  = 2'd1,
        OUT_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          done_q, done_d;
    logic          rd_wr_q, rd_wr_d;
    logic          timeout_q, timeout_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          expire;

`ifdef IO_TIMEOUT_EN
    logic [TW-1:0] cnt_q, cnt_d;

    assign expire = (cnt_q == TW'(TMO_CYCLES - 1));
`else
    logic [TW-1:0] unused_tmo;

    assign unused_tmo = TW'(TMO_CYCLES);
    assign expire     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rd_data_d   = rd_data_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        rd_wr_d     = 1'b0;
        timeout_d   = 1'b0;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
`ifdef IO_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef IO_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (io_req) begin
                    if (io_op) begin
                        out_data_d  = wr_data;
                        out_valid_d = 1'b1;
                        state_d     = OUT_WAIT;
                    end else begin
                        in_ready_d = 1'b1;
                        state_d    = IN_WAIT;
                    end
                end
            end
            IN_WAIT: begin
                // A handshake on the expiry cycle still completes normally.
                if (in_valid) begin
                    rd_data_d = in_data;
                    done_d    = 1'b1;
                    rd_wr_d   = 1'b1;
                    state_d   = DONE;
                end else if (expire) begin
                    rd_data_d = '0;
                    done_d    = 1'b1;
                    rd_wr_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    in_ready_d = 1'b1;
`ifdef IO_TIMEOUT_EN
                    cnt_d = cnt_q + TW'(1);
`endif
                end
            end
            OUT_WAIT: begin
                if (out_ready) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (expire) begin
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    out_valid_d = 1'b1;
`ifdef IO_TIMEOUT_EN
                    cnt_d = cnt_q + TW'(1);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_data_q   <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            rd_wr_q     <= 1'b0;
            timeout_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef IO_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rd_data_q   <= rd_data_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            rd_wr_q     <= rd_wr_d;
            timeout_q   <= timeout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef IO_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // in_ready/out_valid mirror the WAIT states, so they also stand for them here.
    assign stall     = ((state_q == IDLE) && io_req) | in_ready_q | out_valid_q;
    assign done      = done_q;
    assign rd_wr     = rd_wr_q;
    assign timeout   = timeout_q;
    assign rd_data   = rd_data_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_io_handshake_ctrl.sv
// Self-checking bench for io_handshake_ctrl: directed and randomized transfers
// against a transaction-level model of handshake latency, timeout and captured data.
module tb_io_handshake_ctrl;

    localparam int DW  = 8;
    localparam int TMO = 4;
    localparam int TW  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          io_req;
    logic          io_op;
    logic [DW-1:0] wr_data;
    logic          stall;
    logic          done;
    logic [DW-1:0] rd_data;
    logic          rd_wr;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          timeout;

    io_handshake_ctrl #(
        .DW(DW),
        .TMO_CYCLES(TMO),
        .TW(TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io_req(io_req),
        .io_op(io_op),
        .wr_data(wr_data),
        .stall(stall),
        .done(done),
        .rd_data(rd_data),
        .rd_wr(rd_wr),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [DW-1:0] rd_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One transfer: partner responds from wait-cycle index d onward.
    // Completion edge (counting the request edge as 0) is 1 + d, or 1 + (TMO-1)
    // when the watchdog expires first; the handshake wins on the expiry cycle.
    task automatic xfer(input logic op, input logic [DW-1:0] wd,
                        input logic [DW-1:0] id, input int d, input bit noisy);
        int edone;
        bit tmo;
        bit hs;
`ifdef IO_TIMEOUT_EN
        tmo   = (d > TMO - 1);
        edone = 1 + (tmo ? TMO - 1 : d);
`else
        tmo   = 1'b0;
        edone = 1 + d;
`endif
        @(negedge clk);
        io_req    = 1'b1;
        io_op     = op;
        wr_data   = wd;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("stall_on_req", stall, 1);
        chk("done_idle", done, 0);
        for (int e = 0; e <= edone + 1; e++) begin
            @(negedge clk);
            hs = (e >= d) && (e < edone);
            if (e <= edone && noisy) begin
                io_req  = 1'($urandom_range(0, 1));
                io_op   = 1'($urandom_range(0, 1));
                wr_data = DW'($urandom);
            end else begin
                io_req = 1'b0;
            end
            if (op) begin
                out_ready = hs | ((e >= edone) && noisy && 1'($urandom_range(0, 1)));
                in_valid  = noisy && 1'($urandom_range(0, 1));
                in_data   = DW'($urandom);
            end else begin
                in_valid  = hs | ((e >= edone) && noisy && 1'($urandom_range(0, 1)));
                in_data   = hs ? id : DW'($urandom);
                out_ready = noisy && 1'($urandom_range(0, 1));
            end
            #1;
            if (e < edone) begin
                chk("stall_wait", stall, 1);
                chk("done_wait", done, 0);
                chk("in_ready_wait", in_ready, !op);
                chk("out_valid_wait", out_valid, op);
                chk("rd_data_hold", rd_data, rd_exp);
                if (op) chk("out_data_wait", out_data, wd);
            end else if (e == edone) begin
                if (!op) rd_exp = tmo ? '0 : id;
                chk("done_pulse", done, 1);
                chk("rd_wr_done", rd_wr, !op);
                chk("timeout_done", timeout, tmo);
                chk("stall_done", stall, 0);
                chk("in_ready_done", in_ready, 0);
                chk("out_valid_done", out_valid, 0);
                chk("rd_data_done", rd_data, rd_exp);
            end else begin
                chk("done_after", done, 0);
                chk("rd_wr_after", rd_wr, 0);
                chk("stall_after", stall, 0);
                chk("in_ready_after", in_ready, 0);
                chk("out_valid_after", out_valid, 0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        io_req    = 1'b0;
        io_op     = 1'b0;
        wr_data   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rd_exp    = '0;
        #12;
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_rd_wr", rd_wr, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;

        xfer(1'b1, 8'hA5, 8'h00, 0, 1'b0);
        xfer(1'b0, 8'h00, 8'h3C, 5, 1'b0);
        xfer(1'b1, 8'h5A, 8'h00, 3, 1'b1);
        xfer(1'b0, 8'h00, 8'hC3, 0, 1'b1);

        // Reset while waiting for input data.
        @(negedge clk);
        io_req = 1'b1;
        io_op  = 1'b0;
        @(negedge clk);
        io_req = 1'b0;
        #1;
        chk("pre_rst_in_ready", in_ready, 1);
        #2;
        rst = 1'b1;
        #1;
        rd_exp = '0;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_done", done, 0);
            chk("post_rst_in_ready", in_ready, 0);
        end

`ifdef IO_TIMEOUT_EN
        xfer(1'b0, 8'h00, 8'h77, 20, 1'b0);
        xfer(1'b1, 8'h99, 8'h00, TMO - 1, 1'b0);
        xfer(1'b1, 8'h66, 8'h00, TMO, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            xfer(1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom),
                 int'($urandom_range(0, 7)), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
